bus_controller: RTL and testbench
=================================

BUS_CONTROLLER -- requirements
Module: bus_controller

Interface
REQ-001 The module SHALL have a parameter ROM_WAIT, default 3: CLK cycles from ROM chip select to ROM DSACK.
REQ-002 The module SHALL have a parameter IO_WAIT, default 6: CLK cycles from IO chip select to IO DSACK.
REQ-003 The module SHALL have a parameter BERR_TIMEOUT, default 1023: CLK cycles of unacknowledged AS before bus error.
REQ-004 The module SHALL have a parameter BOOT_CYCLES, default 4: completed bus cycles before the boot overlay clears.
REQ-005 CLK  in  1  system clock, 50 MHz.
REQ-006 RST_n  in  1  reset, synchronous, active-low.
REQ-007 AS_n  in  1  CPU address strobe (CPU clock domain).
REQ-008 RW  in  1  CPU read/write, 1 = read.
REQ-009 FC  in  3  CPU function code.
REQ-010 ADDR  in  12  CPU address bits [31:20].
REQ-011 DSACK0_DRAM_n, DSACK1_DRAM_n  in  1 each  acknowledges from the DRAM controller.
REQ-012 CS_DRAM_n, CS_ROM_n, CS_IO_n  out  1 each  registered chip selects, active-low.
REQ-013 DSACK0_n, DSACK1_n  out  1 each  registered combined acknowledge to the CPU.
REQ-014 BERR_n  out  1  registered bus error to the CPU.

Function
REQ-015 AS_n SHALL pass through a 2-flop CLK synchronizer, giving as_s; all decisions use as_s.
REQ-016 Decode SHALL be: CPU space (FC=111) maps to none; ADDR[31:28]=0 maps to DRAM; ADDR=FFF maps to ROM; ADDR=FFE maps to IO; everything else maps to none.
REQ-017 While overlay=1, a read with ADDR[31:28]=0 SHALL decode to ROM, and a write there SHALL decode to DRAM.
REQ-018 The FSM SHALL have the states IDLE, DECODE, DRAM, WAIT, ACK, NOMAP and END.
REQ-019 IDLE SHALL go to DECODE on the first edge with as_s=0; DECODE SHALL latch the region and, on the next edge, assert exactly one CS_n (or none) and enter DRAM, WAIT or NOMAP.
REQ-020 In DRAM, DSACK0_n/DSACK1_n SHALL equal DSACK0_DRAM_n/DSACK1_DRAM_n delayed by one CLK.
REQ-021 WAIT SHALL load the counter with ROM_WAIT or IO_WAIT and decrement it once per CLK; at 0, ROM SHALL assert DSACK1_n only (16-bit port) and IO SHALL assert DSACK0_n only (8-bit port), and the FSM SHALL enter ACK.
REQ-022 NOMAP SHALL assert no CS_n and no DSACK.
REQ-023 From any state other than IDLE, as_s=1 SHALL cause entry to END on the next edge (this includes an abort from DECODE or WAIT).
REQ-024 END SHALL negate all CS_n, DSACK and BERR_n, increment the 3-bit boot counter (saturating), and return to IDLE after one cycle.
REQ-025 When the boot counter reaches BOOT_CYCLES, overlay SHALL clear; overlay SHALL be set again only by reset.
REQ-026 A new AS assertion detected while in END SHALL be handled starting from IDLE; no cycle is dropped.

Reset
REQ-027 While RST_n=0 at an edge, the module SHALL drive all CS_n, DSACK0_n, DSACK1_n and BERR_n to 1, state to IDLE, all counters to 0, overlay to 1, and the synchronizer flops to 1.
REQ-028 A reset asserted mid-cycle SHALL negate all outputs at the next edge, independent of AS_n.

Configuration
REQ-029 With BERR_TIMEOUT_EN defined, a 10-bit watchdog SHALL count CLK cycles while as_s=0 and both DSACK outputs are 1; on reaching BERR_TIMEOUT it SHALL drive BERR_n=0 and hold it until END.
REQ-030 The watchdog SHALL clear whenever as_s=1 or any DSACK output is 0.
REQ-031 Without BERR_TIMEOUT_EN, the watchdog SHALL not exist, BERR_n SHALL be constant 1, and NOMAP SHALL wait for as_s=1 indefinitely.

Verification
REQ-032 Reset, then four reads at ADDR=0x000 with FC=110 -> CS_ROM_n low each time, DSACK1_n low 3 CLK after CS; on the 5th read at 0x000, CS_DRAM_n is low.
REQ-033 Write at 0x000 during overlay -> CS_DRAM_n low, CS_ROM_n high; DRAM DSACK low at cycle N -> DSACK0_n/DSACK1_n low at N+1.
REQ-034 Read at ADDR=0xFFE -> CS_IO_n low, DSACK0_n low after 6 CLK, DSACK1_n stays 1; AS_n high -> all outputs negated within 4 CLK.
REQ-035 With macro defined, read at ADDR=0x800 -> no CS, BERR_n low exactly 1023 CLK after as_s falls; without macro, BERR_n stays 1 for 5000 CLK.
REQ-036 AS_n negated 2 CLK into a ROM WAIT, or RST_n low mid-DRAM cycle -> CS_n and DSACK negated, FSM in IDLE, overlay=1 after reset.

Source files
------------

// File: rtl/bus_controller.sv
// -----------------------------------------------------------------------------
// bus_controller
//
// Chip-select decode and bus-cycle sequencing for a 68k-style CPU bus.
// The CPU address strobe is synchronised into the CLK domain. Each bus cycle
// is decoded to DRAM, ROM, IO or an unmapped region:
//   - DRAM forwards the DRAM controller's acknowledges, delayed by one CLK.
//   - ROM (16-bit port) is acknowledged on DSACK1_n after ROM_WAIT clocks.
//   - IO (8-bit port) is acknowledged on DSACK0_n after IO_WAIT clocks.
//   - An unmapped cycle asserts no chip select and no acknowledge.
// After reset a boot overlay maps reads of the low 256 MB to ROM. The overlay
// clears once BOOT_CYCLES bus cycles have completed, and only reset sets it
// again.
//
// Optional feature (macro BERR_TIMEOUT_EN): a 10-bit watchdog counts clocks
// while the strobe is asserted and neither acknowledge is driven. When it
// reaches BERR_TIMEOUT, BERR_n is asserted and held until the cycle ends.
// Without the macro, BERR_n is constant 1 and an unmapped cycle waits for
// the strobe to negate, however long that takes.
//
// Parameters:
//   ROM_WAIT      CLK cycles from ROM chip select to ROM DSACK
//   IO_WAIT       CLK cycles from IO chip select to IO DSACK
//   BERR_TIMEOUT  CLK cycles of unacknowledged AS before bus error
//   BOOT_CYCLES   completed bus cycles before the boot overlay clears
//
// Ports:
//   CLK            in   system clock (50 MHz)
//   RST_n          in   synchronous active-low reset
//   AS_n           in   CPU address strobe (asynchronous to CLK)
//   RW             in   CPU read/write, 1 = read
//   FC[2:0]        in   CPU function code
//   ADDR[11:0]     in   CPU address bits [31:20]
//   DSACK0_DRAM_n  in   DRAM controller acknowledge, byte lane 0
//   DSACK1_DRAM_n  in   DRAM controller acknowledge, byte lane 1
//   CS_DRAM_n      out  registered DRAM chip select
//   CS_ROM_n       out  registered ROM chip select
//   CS_IO_n        out  registered IO chip select
//   DSACK0_n       out  registered acknowledge to the CPU, lane 0
//   DSACK1_n       out  registered acknowledge to the CPU, lane 1
//   BERR_n         out  registered bus error to the CPU
// -----------------------------------------------------------------------------
module bus_controller #(
    parameter int ROM_WAIT     = 3,
    parameter int IO_WAIT      = 6,
    parameter int BERR_TIMEOUT = 1023,
    parameter int BOOT_CYCLES  = 4
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        AS_n,
    input  logic        RW,
    input  logic [2:0]  FC,
    input  logic [11:0] ADDR,
    input  logic        DSACK0_DRAM_n,
    input  logic        DSACK1_DRAM_n,
    output logic        CS_DRAM_n,
    output logic        CS_ROM_n,
    output logic        CS_IO_n,
    output logic        DSACK0_n,
    output logic        DSACK1_n,
    output logic        BERR_n
);

    // FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_DRAM   = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_ACK    = 3'd4;
    localparam logic [2:0] ST_NOMAP  = 3'd5;
    localparam logic [2:0] ST_END    = 3'd6;

    // Decoded regions
    localparam logic [1:0] REG_NONE = 2'd0;
    localparam logic [1:0] REG_DRAM = 2'd1;
    localparam logic [1:0] REG_ROM  = 2'd2;
    localparam logic [1:0] REG_IO   = 2'd3;

    localparam int         WAIT_W      = 8;
    localparam logic [WAIT_W-1:0] ROM_WAIT_LD = WAIT_W'(ROM_WAIT);
    localparam logic [WAIT_W-1:0] IO_WAIT_LD  = WAIT_W'(IO_WAIT);

    // Address decode. CPU space never selects a device; the overlay only
    // redirects reads of the DRAM window, so boot-time writes still land in
    // DRAM.
    function automatic logic [1:0] decode_region(
        input logic [2:0]  fc,
        input logic [11:0] addr,
        input logic        rw,
        input logic        ovl
    );
        logic [1:0] region_v;
        if (fc == 3'b111) begin
            region_v = REG_NONE;
        end else if (addr[11:8] == 4'h0) begin
            region_v = (ovl && rw) ? REG_ROM : REG_DRAM;
        end else if (addr == 12'hFFF) begin
            region_v = REG_ROM;
        end else if (addr == 12'hFFE) begin
            region_v = REG_IO;
        end else begin
            region_v = REG_NONE;
        end
        return region_v;
    endfunction

    logic              as_meta_r;
    logic              as_sync_r;
    logic              as_s;

    logic [2:0]        state_r,   state_nx;
    logic [1:0]        region_r,  region_nx;
    logic [WAIT_W-1:0] wait_r,    wait_nx;
    logic [2:0]        boot_r,    boot_nx;
    logic              overlay_r, overlay_nx;

    logic              cs_dram_r, cs_dram_nx;
    logic              cs_rom_r,  cs_rom_nx;
    logic              cs_io_r,   cs_io_nx;
    logic              dsack0_r,  dsack0_nx;
    logic              dsack1_r,  dsack1_nx;
    logic              berr_r,    berr_nx;

    logic              release_s;
    logic [1:0]        dec_region_s;

`ifdef BERR_TIMEOUT_EN
    localparam logic [9:0] WD_LIMIT = 10'(BERR_TIMEOUT);
    logic [9:0]        wdog_r, wdog_nx;
`endif

    assign as_s = as_sync_r;

    // Two-flop synchroniser for the CPU address strobe (idles high)
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            as_meta_r <= 1'b1;
            as_sync_r <= 1'b1;
        end else begin
            as_meta_r <= AS_n;
            as_sync_r <= as_meta_r;
        end
    end

    assign dec_region_s = decode_region(FC, ADDR, RW, overlay_r);

    // Next-state, counters and next registered output values
    always_comb begin
        state_nx   = state_r;
        region_nx  = region_r;
        wait_nx    = wait_r;
        boot_nx    = boot_r;
        overlay_nx = overlay_r;
        cs_dram_nx = cs_dram_r;
        cs_rom_nx  = cs_rom_r;
        cs_io_nx   = cs_io_r;
        dsack0_nx  = dsack0_r;
        dsack1_nx  = dsack1_r;
        release_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                release_s = 1'b1;
                if (!as_s) begin
                    state_nx = ST_DECODE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end

            ST_DECODE: begin
                if (as_s) begin
                    // Strobe withdrawn before any device was selected
                    state_nx  = ST_END;
                    release_s = 1'b1;
                end else begin
                    region_nx = dec_region_s;
                    case (dec_region_s)
                        REG_DRAM: begin
                            cs_dram_nx = 1'b0;
                            state_nx   = ST_DRAM;
                        end
                        REG_ROM: begin
                            cs_rom_nx = 1'b0;
                            wait_nx   = ROM_WAIT_LD;
                            state_nx  = ST_WAIT;
                        end
                        REG_IO: begin
                            cs_io_nx = 1'b0;
                            wait_nx  = IO_WAIT_LD;
                            state_nx = ST_WAIT;
                        end
                        default: begin
                            state_nx = ST_NOMAP;
                        end
                    endcase
                end
            end

            ST_DRAM: begin
                if (as_s) begin
                    state_nx  = ST_END;
                    release_s = 1'b1;
                end else begin
                    // Registering here gives the one-CLK forwarding delay
                    dsack0_nx = DSACK0_DRAM_n;
                    dsack1_nx = DSACK1_DRAM_n;
                end
            end

            ST_WAIT: begin
                if (as_s) begin
                    state_nx  = ST_END;
                    release_s = 1'b1;
                end else if (wait_r <= 8'd1) begin
                    // Counter reaches 0 on the same edge the acknowledge is
                    // registered, so DSACK lands exactly *_WAIT clocks after CS.
                    wait_nx  = 8'd0;
                    state_nx = ST_ACK;
                    if (region_r == REG_ROM) begin
                        dsack1_nx = 1'b0;
                    end else begin
                        dsack0_nx = 1'b0;
                    end
                end else begin
                    wait_nx = wait_r - 8'd1;
                end
            end

            ST_ACK, ST_NOMAP: begin
                if (as_s) begin
                    state_nx  = ST_END;
                    release_s = 1'b1;
                end else begin
                    state_nx = state_r;
                end
            end

            ST_END: begin
                release_s = 1'b1;
                state_nx  = ST_IDLE;
                boot_nx   = (boot_r == 3'd7) ? boot_r : boot_r + 3'd1;
                if (int'(boot_nx) >= BOOT_CYCLES) begin
                    overlay_nx = 1'b0;
                end else begin
                    overlay_nx = overlay_r;
                end
            end

            default: begin
                state_nx  = ST_IDLE;
                release_s = 1'b1;
            end
        endcase

        if (release_s) begin
            cs_dram_nx = 1'b1;
            cs_rom_nx  = 1'b1;
            cs_io_nx   = 1'b1;
            dsack0_nx  = 1'b1;
            dsack1_nx  = 1'b1;
        end else begin
            cs_dram_nx = cs_dram_nx;
        end
    end

`ifdef BERR_TIMEOUT_EN
    // Bus-error watchdog: counts unacknowledged strobe clocks, saturating
    always_comb begin
        if (as_s || !dsack0_r || !dsack1_r) begin
            wdog_nx = 10'd0;
        end else if (wdog_r == 10'h3FF) begin
            wdog_nx = wdog_r;
        end else begin
            wdog_nx = wdog_r + 10'd1;
        end

        if (state_nx == ST_END) begin
            berr_nx = 1'b1;
        end else if (wdog_nx == WD_LIMIT) begin
            berr_nx = 1'b0;
        end else begin
            berr_nx = berr_r;
        end
    end

    // Watchdog counter register
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            wdog_r <= 10'd0;
        end else begin
            wdog_r <= wdog_nx;
        end
    end
`else
    // No watchdog in this build: bus error is never raised
    always_comb begin
        berr_nx = 1'b1;
    end
`endif

    // FSM, counters, overlay and registered outputs
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_r   <= ST_IDLE;
            region_r  <= REG_NONE;
            wait_r    <= 8'd0;
            boot_r    <= 3'd0;
            overlay_r <= 1'b1;
            cs_dram_r <= 1'b1;
            cs_rom_r  <= 1'b1;
            cs_io_r   <= 1'b1;
            dsack0_r  <= 1'b1;
            dsack1_r  <= 1'b1;
            berr_r    <= 1'b1;
        end else begin
            state_r   <= state_nx;
            region_r  <= region_nx;
            wait_r    <= wait_nx;
            boot_r    <= boot_nx;
            overlay_r <= overlay_nx;
            cs_dram_r <= cs_dram_nx;
            cs_rom_r  <= cs_rom_nx;
            cs_io_r   <= cs_io_nx;
            dsack0_r  <= dsack0_nx;
            dsack1_r  <= dsack1_nx;
            berr_r    <= berr_nx;
        end
    end

    assign CS_DRAM_n = cs_dram_r;
    assign CS_ROM_n  = cs_rom_r;
    assign CS_IO_n   = cs_io_r;
    assign DSACK0_n  = dsack0_r;
    assign DSACK1_n  = dsack1_r;
    assign BERR_n    = berr_r;

endmodule

// File: tb/tb_bus_controller.sv
// -----------------------------------------------------------------------------
// tb_bus_controller
//
// Directed and randomised bus cycles against bus_controller. The expected
// output of every clock is computed from a cycle-level view of the bus:
// chip select appears a fixed number of clocks after AS_n falls (two
// synchroniser clocks plus IDLE->DECODE->select), acknowledges follow the
// region's wait rules, and everything is released three clocks after AS_n
// rises. The boot overlay is modelled as a count of finished bus cycles.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_bus_controller;

    localparam int ROM_WAIT     = 3;
    localparam int IO_WAIT      = 6;
    localparam int BERR_TIMEOUT = 1023;
    localparam int BOOT_CYCLES  = 4;
    localparam int CS_LAT       = 4;   // clocks from AS_n low to chip select

    localparam int R_NONE = 0;
    localparam int R_DRAM = 1;
    localparam int R_ROM  = 2;
    localparam int R_IO   = 3;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        AS_n = 1'b1;
    logic        RW = 1'b1;
    logic [2:0]  FC = 3'b101;
    logic [11:0] ADDR = 12'h000;
    logic        DSACK0_DRAM_n = 1'b1;
    logic        DSACK1_DRAM_n = 1'b1;
    logic        CS_DRAM_n, CS_ROM_n, CS_IO_n, DSACK0_n, DSACK1_n, BERR_n;

    logic [5:0]  obs;
    logic [1:0]  drv [0:8191];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cycles = 0;

    always #10 CLK = ~CLK;

    bus_controller #(
        .ROM_WAIT    (ROM_WAIT),
        .IO_WAIT     (IO_WAIT),
        .BERR_TIMEOUT(BERR_TIMEOUT),
        .BOOT_CYCLES (BOOT_CYCLES)
    ) dut (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .AS_n         (AS_n),
        .RW           (RW),
        .FC           (FC),
        .ADDR         (ADDR),
        .DSACK0_DRAM_n(DSACK0_DRAM_n),
        .DSACK1_DRAM_n(DSACK1_DRAM_n),
        .CS_DRAM_n    (CS_DRAM_n),
        .CS_ROM_n     (CS_ROM_n),
        .CS_IO_n      (CS_IO_n),
        .DSACK0_n     (DSACK0_n),
        .DSACK1_n     (DSACK1_n),
        .BERR_n       (BERR_n)
    );

    // {CS_DRAM_n, CS_ROM_n, CS_IO_n, DSACK0_n, DSACK1_n, BERR_n}
    assign obs = {CS_DRAM_n, CS_ROM_n, CS_IO_n, DSACK0_n, DSACK1_n, BERR_n};

    function automatic int model_region(input logic [2:0] fc, input logic [11:0] addr,
                                        input logic rw, input int finished);
        bit ovl;
        ovl = (finished < BOOT_CYCLES);
        if (fc == 3'b111)     return R_NONE;
        if (addr < 12'h100)   return (ovl && rw) ? R_ROM : R_DRAM;
        if (addr == 12'hFFF)  return R_ROM;
        if (addr == 12'hFFE)  return R_IO;
        return R_NONE;
    endfunction

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int cycles, input string tag);
        RST_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            step();
            check(tag, obs, 6'b111111);
        end
        RST_n = 1'b1;
        done_cycles = 0;
    endtask

    task automatic idle_steps(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            DSACK0_DRAM_n = 1'($urandom);
            DSACK1_DRAM_n = 1'($urandom);
            check(tag, obs, 6'b111111);
        end
        DSACK0_DRAM_n = 1'b1;
        DSACK1_DRAM_n = 1'b1;
    endtask

    // One complete bus cycle: AS_n low for `hold` clocks, then released.
    task automatic run_cycle(input logic rw, input logic [2:0] fc, input logic [11:0] addr,
                             input int hold, input string tag);
        int         region;
        logic [5:0] exp;
        region = model_region(fc, addr, rw, done_cycles);
        RW   = rw;
        FC   = fc;
        ADDR = addr;
        AS_n = 1'b0;
        drv[0] = 2'($urandom);
        {DSACK0_DRAM_n, DSACK1_DRAM_n} = drv[0];
        for (int c = 1; c <= hold + 3; c++) begin
            step();
            exp = 6'b111111;
            if (c >= CS_LAT && c <= hold + 2) begin
                case (region)
                    R_DRAM: begin
                        exp[5] = 1'b0;
                        if (c > CS_LAT) exp[2:1] = drv[c-1];
                    end
                    R_ROM: begin
                        exp[4] = 1'b0;
                        if (c >= CS_LAT + ROM_WAIT) exp[1] = 1'b0;
                    end
                    R_IO: begin
                        exp[3] = 1'b0;
                        if (c >= CS_LAT + IO_WAIT) exp[2] = 1'b0;
                    end
                    default: begin
`ifdef BERR_TIMEOUT_EN
                        // strobe seen low two clocks after AS_n falls
                        if (c >= 2 + BERR_TIMEOUT) exp[0] = 1'b0;
`endif
                    end
                endcase
            end
            check($sformatf("%s@%0d", tag, c), obs, exp);
            if (c == hold) AS_n = 1'b1;
            drv[c] = (c <= hold + 1) ? 2'($urandom) : 2'b11;
            {DSACK0_DRAM_n, DSACK1_DRAM_n} = drv[c];
        end
        done_cycles++;
    endtask

    initial begin
        logic [11:0] a;
        int          sel;

        // Reset state
        do_reset(3, "reset");
        idle_steps(2, "idle_after_reset");

        // Boot overlay: four reads at 0x000 hit ROM, the fifth hits DRAM
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b1, 3'b110, 12'h000, 10, $sformatf("boot_rom%0d", i));
            idle_steps(1, "gap");
        end
        run_cycle(1'b1, 3'b110, 12'h000, 10, "post_boot_dram");
        idle_steps(1, "gap");

        // Reset in the middle of an acknowledged DRAM cycle
        RW = 1'b1; FC = 3'b101; ADDR = 12'h010; AS_n = 1'b0;
        DSACK0_DRAM_n = 1'b0; DSACK1_DRAM_n = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == CS_LAT) check("mid_dram_cs", obs, 6'b011111);
            if (c > CS_LAT)  check("mid_dram_ack", obs, 6'b011001);
        end
        do_reset(2, "mid_dram_reset");
        AS_n = 1'b1;
        DSACK0_DRAM_n = 1'b1; DSACK1_DRAM_n = 1'b1;
        idle_steps(3, "after_mid_reset");

        // Overlay is back after reset: read -> ROM, write -> DRAM
        run_cycle(1'b1, 3'b110, 12'h000, 8, "post_reset_rom");
        idle_steps(1, "gap");
        run_cycle(1'b0, 3'b101, 12'h000, 12, "ovl_write");
        idle_steps(2, "gap");

        // IO read, then release
        run_cycle(1'b1, 3'b101, 12'hFFE, 12, "io_read");
        run_cycle(1'b1, 3'b101, 12'hFFF, 12, "rom_hi_back2back");

        // Aborts: AS_n released two clocks into ROM WAIT, and during DECODE
        run_cycle(1'b1, 3'b110, 12'hFFF, CS_LAT + 2, "rom_abort");
        run_cycle(1'b1, 3'b110, 12'hFFF, 1, "decode_abort");
        run_cycle(1'b1, 3'b110, 12'hFFE, CS_LAT + 3, "io_abort");
        idle_steps(1, "gap");

        // CPU space and unmapped accesses
        run_cycle(1'b1, 3'b111, 12'hFFF, 8, "cpu_space");
`ifdef BERR_TIMEOUT_EN
        run_cycle(1'b1, 3'b101, 12'h800, BERR_TIMEOUT + 20, "unmapped_berr");
`else
        run_cycle(1'b1, 3'b101, 12'h800, 5000, "unmapped_hold");
`endif
        idle_steps(2, "gap");

        // Randomised cycles
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0:       a = 12'h000;
                1:       a = {4'h0, 8'($urandom)};
                2:       a = 12'hFFF;
                3:       a = 12'hFFE;
                4:       a = 12'h800;
                default: a = 12'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) begin
                do_reset(2, "rand_reset");
                idle_steps(1, "gap");
            end
            run_cycle(1'($urandom), 3'($urandom), a, $urandom_range(1, 14),
                      $sformatf("rand%0d", i));
            idle_steps($urandom_range(0, 2), "rand_gap");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
